// File: rtl/branch_check_array_pkg.sv
// rtl/branch_check_array_pkg.sv - condition-word layout and pipeline depth shared by the branch check array
package branch_check_array_pkg;

    localparam int PIPE_DEPTH = 3;

    // Condition word is {enable, negate, flag_sel}; the upper two fields sit directly above flag_sel.
    localparam int COND_FLAG_SEL_LSB = 0;

    function automatic int cond_negate_bit(input int flags_addr_width);
        return flags_addr_width;
    endfunction

    function automatic int cond_enable_bit(input int flags_addr_width);
        return flags_addr_width + 1;
    endfunction

endpackage

// File: rtl/branch_check_array_if.sv
// rtl/branch_check_array_if.sv - write bus for the branch origin, destination and condition memories
interface branch_check_array_if #(
    parameter int PC_WIDTH   = 10,
    parameter int ADDR_WIDTH = 5,
    parameter int COND_WIDTH = 5
);
    logic                  wren_BO;
    logic                  wren_BD;
    logic                  wren_BC;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [PC_WIDTH-1:0]   write_data_BO;
    logic [PC_WIDTH-1:0]   write_data_BD;
    logic [COND_WIDTH-1:0] write_data_BC;

    modport master (
        output wren_BO, wren_BD, wren_BC, write_addr,
        output write_data_BO, write_data_BD, write_data_BC
    );

    modport slave (
        input wren_BO, wren_BD, wren_BC, write_addr,
        input write_data_BO, write_data_BD, write_data_BC
    );

endinterface

// File: rtl/branch_entry_match.sv
// rtl/branch_entry_match.sv - origin compare and flag condition evaluation for one branch entry
module branch_entry_match
    import branch_check_array_pkg::*;
#(
    parameter int PC_WIDTH         = 10,
    parameter int FLAGS_WIDTH      = 8,
    parameter int FLAGS_ADDR_WIDTH = 3
) (
    input  logic [PC_WIDTH-1:0]         pc,
    input  logic [PC_WIDTH-1:0]         origin,
    input  logic [FLAGS_ADDR_WIDTH+1:0] cond_word,
    input  logic [FLAGS_WIDTH-1:0]      flags,
    output logic                        hit,
    output logic                        cond_true
);

    localparam int ENABLE_BIT = cond_enable_bit(FLAGS_ADDR_WIDTH);
    localparam int NEGATE_BIT = cond_negate_bit(FLAGS_ADDR_WIDTH);

    logic [FLAGS_ADDR_WIDTH-1:0] flag_sel;

    assign flag_sel  = cond_word[COND_FLAG_SEL_LSB +: FLAGS_ADDR_WIDTH];
    assign hit       = (origin == pc) && cond_word[ENABLE_BIT];
    assign cond_true = flags[flag_sel] ^ cond_word[NEGATE_BIT];

endmodule

// File: rtl/branch_check_array.sv
// rtl/branch_check_array.sv - 3-stage per-thread branch lookup; BRANCH_CHECK_REPLAY_EN adds I/O-stall decision replay
module branch_check_array
    import branch_check_array_pkg::*;
#(
    parameter int PC_WIDTH          = 10,
    parameter int THREAD_COUNT      = 8,
    parameter int THREAD_ADDR_WIDTH = 3,
    parameter int INITIAL_THREAD    = 0,
    parameter int BRANCH_COUNT      = 4,
    parameter int ENTRY_ADDR_WIDTH  = 2,
    parameter int FLAGS_WIDTH       = 8,
    parameter int FLAGS_ADDR_WIDTH  = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PC_WIDTH-1:0]         PC,
    input  logic [FLAGS_WIDTH-1:0]      flags,
    input  logic                        IO_ready_previous,
    branch_check_array_if.slave         wr,
    output logic [PC_WIDTH-1:0]         branch_destination,
    output logic                        jump,
    output logic [ENTRY_ADDR_WIDTH-1:0] jump_entry
);

    localparam int COND_WIDTH = FLAGS_ADDR_WIDTH + 2;
    localparam int MEM_DEPTH  = THREAD_COUNT * BRANCH_COUNT;
    localparam int DEC_WIDTH  = 1 + ENTRY_ADDR_WIDTH + PC_WIDTH;

    // Branch memories are deliberately unreset; software loads them before use.
    logic [PC_WIDTH-1:0]   origin_mem [MEM_DEPTH];
    logic [PC_WIDTH-1:0]   dest_mem   [MEM_DEPTH];
    logic [COND_WIDTH-1:0] cond_mem   [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (wr.wren_BO) origin_mem[wr.write_addr] <= wr.write_data_BO;
        if (wr.wren_BD) dest_mem[wr.write_addr]   <= wr.write_data_BD;
        if (wr.wren_BC) cond_mem[wr.write_addr]   <= wr.write_data_BC;
    end

    logic [THREAD_ADDR_WIDTH-1:0] thread_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thread_q <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
        end else if (thread_q == THREAD_ADDR_WIDTH'(THREAD_COUNT - 1)) begin
            thread_q <= '0;
        end else begin
            thread_q <= thread_q + 1'b1;
        end
    end

    // Stage 1: PC and all entries of the current thread, read with old-data semantics.
    logic [PC_WIDTH-1:0]   pc_s1;
    logic [PC_WIDTH-1:0]   origin_s1 [BRANCH_COUNT];
    logic [PC_WIDTH-1:0]   dest_s1   [BRANCH_COUNT];
    logic [COND_WIDTH-1:0] cond_s1   [BRANCH_COUNT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_s1 <= '0;
            for (int i = 0; i < BRANCH_COUNT; i++) begin
                origin_s1[i] <= '0;
                dest_s1[i]   <= '0;
                cond_s1[i]   <= '0;
            end
        end else begin
            pc_s1 <= PC;
            for (int i = 0; i < BRANCH_COUNT; i++) begin
                origin_s1[i] <= origin_mem[{thread_q, ENTRY_ADDR_WIDTH'(i)}];
                dest_s1[i]   <= dest_mem[{thread_q, ENTRY_ADDR_WIDTH'(i)}];
                cond_s1[i]   <= cond_mem[{thread_q, ENTRY_ADDR_WIDTH'(i)}];
            end
        end
    end

    logic [BRANCH_COUNT-1:0] hit_s1;
    logic [BRANCH_COUNT-1:0] cond_true_s1;

    for (genvar g = 0; g < BRANCH_COUNT; g++) begin : g_entry
        branch_entry_match #(
            .PC_WIDTH         (PC_WIDTH),
            .FLAGS_WIDTH      (FLAGS_WIDTH),
            .FLAGS_ADDR_WIDTH (FLAGS_ADDR_WIDTH)
        ) u_match (
            .pc        (pc_s1),
            .origin    (origin_s1[g]),
            .cond_word (cond_s1[g]),
            .flags     (flags),
            .hit       (hit_s1[g]),
            .cond_true (cond_true_s1[g])
        );
    end

    // Stage 2: only entries that both hit and pass their condition compete.
    logic [BRANCH_COUNT-1:0] match_s2;
    logic [PC_WIDTH-1:0]     dest_s2 [BRANCH_COUNT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match_s2 <= '0;
            for (int i = 0; i < BRANCH_COUNT; i++) dest_s2[i] <= '0;
        end else begin
            match_s2 <= hit_s1 & cond_true_s1;
            for (int i = 0; i < BRANCH_COUNT; i++) dest_s2[i] <= dest_s1[i];
        end
    end

    logic                        jump_raw;
    logic [ENTRY_ADDR_WIDTH-1:0] sel_entry;
    logic [PC_WIDTH-1:0]         sel_dest;
    logic [DEC_WIDTH-1:0]        fresh_dec;
    logic [DEC_WIDTH-1:0]        dec_next;

    // Scanning downward lets the lowest matching index win; no match leaves all-zero.
    always_comb begin
        jump_raw  = 1'b0;
        sel_entry = '0;
        sel_dest  = '0;
        for (int i = BRANCH_COUNT - 1; i >= 0; i--) begin
            if (match_s2[i]) begin
                jump_raw  = 1'b1;
                sel_entry = ENTRY_ADDR_WIDTH'(i);
                sel_dest  = dest_s2[i];
            end
        end
    end

    assign fresh_dec = {jump_raw, sel_entry, sel_dest};

`ifdef BRANCH_CHECK_REPLAY_EN
    logic [THREAD_ADDR_WIDTH-1:0] thread_s1;
    logic [THREAD_ADDR_WIDTH-1:0] thread_s2;
    logic [DEC_WIDTH-1:0]         replay_q [THREAD_COUNT];

    // A re-issued instruction repeats its thread's last decision instead of re-deciding on stale flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thread_s1 <= '0;
            thread_s2 <= '0;
            for (int t = 0; t < THREAD_COUNT; t++) replay_q[t] <= '0;
        end else begin
            thread_s1 <= thread_q;
            thread_s2 <= thread_s1;
            if (IO_ready_previous) replay_q[thread_s2] <= fresh_dec;
        end
    end

    assign dec_next = IO_ready_previous ? fresh_dec : replay_q[thread_s2];
`else
    logic io_ready_unused;

    assign io_ready_unused = IO_ready_previous;
    assign dec_next        = fresh_dec;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jump               <= 1'b0;
            jump_entry         <= '0;
            branch_destination <= '0;
        end else begin
            {jump, jump_entry, branch_destination} <= dec_next;
        end
    end

endmodule

// File: tb/tb_branch_check_array.sv
// tb/tb_branch_check_array.sv - table-driven scoreboard bench for branch_check_array
module tb_branch_check_array;
    import branch_check_array_pkg::*;

    localparam int PCW     = 10;
    localparam int TH      = 8;
    localparam int THW     = 3;
    localparam int EW      = 2;
    localparam int FW      = 8;
    localparam int FAW     = 3;
    localparam int CW      = FAW + 2;
    localparam int INIT_TH = 0;
    localparam logic [PCW-1:0] IDLE_PC = 10'h3FF;

    typedef struct {
        int             tag;
        int             thread;
        logic [PCW-1:0] pc;
        logic [FW-1:0]  fl;
        logic           io;
        logic [2:0]     wr_en;
        logic [THW+EW-1:0] wr_addr;
        logic [PCW-1:0] bo;
        logic [PCW-1:0] bd;
        logic [CW-1:0]  bc;
        logic           ej;
        logic [PCW-1:0] ed;
        logic [EW-1:0]  ee;
    } vec_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [PCW-1:0] PC;
    logic [FW-1:0]  flags;
    logic           IO_ready_previous;
    logic [PCW-1:0] branch_destination;
    logic           jump;
    logic [EW-1:0]  jump_entry;

    branch_check_array_if #(.PC_WIDTH(PCW), .ADDR_WIDTH(THW + EW), .COND_WIDTH(CW)) wr_bus ();

    branch_check_array #(
        .PC_WIDTH(PCW), .THREAD_COUNT(TH), .THREAD_ADDR_WIDTH(THW), .INITIAL_THREAD(INIT_TH),
        .BRANCH_COUNT(4), .ENTRY_ADDR_WIDTH(EW), .FLAGS_WIDTH(FW), .FLAGS_ADDR_WIDTH(FAW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .PC                 (PC),
        .flags              (flags),
        .IO_ready_previous  (IO_ready_previous),
        .wr                 (wr_bus),
        .branch_destination (branch_destination),
        .jump               (jump),
        .jump_entry         (jump_entry)
    );

    always #5 clock = ~clock;

    vec_t exp_q[$];
    vec_t tbl[$];
    vec_t prev1, prev2;
    int   tb_thread;
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t idle_rec();
        vec_t r;
        r.tag = -1; r.thread = -1; r.pc = IDLE_PC; r.fl = '0; r.io = 1'b1;
        r.wr_en = '0; r.wr_addr = '0; r.bo = '0; r.bd = '0; r.bc = '0;
        r.ej = 1'b0; r.ed = '0; r.ee = '0;
        return r;
    endfunction

    function automatic vec_t mkv(input int tag, input int th, input logic [PCW-1:0] pc,
                                 input logic [FW-1:0] fl, input logic io, input logic ej,
                                 input logic [PCW-1:0] ed, input logic [EW-1:0] ee);
        vec_t r = idle_rec();
        r.tag = tag; r.thread = th; r.pc = pc; r.fl = fl; r.io = io;
        r.ej = ej; r.ed = ed; r.ee = ee;
        return r;
    endfunction

    task automatic check_out(input vec_t e);
        total++;
        if ({jump, branch_destination, jump_entry} !== {e.ej, e.ed, e.ee}) begin
            bad++;
            $display("FAIL vec%0d thread%0d: got jump=%0b dest=%h entry=%0d, want jump=%0b dest=%h entry=%0d",
                     e.tag, e.thread, jump, branch_destination, jump_entry, e.ej, e.ed, e.ee);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({jump, branch_destination, jump_entry} !== '0) begin
            bad++;
            $display("FAIL %s: got jump=%0b dest=%h entry=%0d, want all zero",
                     name, jump, branch_destination, jump_entry);
        end
    endtask

    // One clock: PC for r, flags for the record one cycle older, I/O-ready for the one two cycles older.
    task automatic issue(input vec_t r);
        vec_t e;
        PC                   = r.pc;
        flags                = prev1.fl;
        IO_ready_previous    = prev2.io;
        wr_bus.wren_BO       = r.wr_en[2];
        wr_bus.wren_BD       = r.wr_en[1];
        wr_bus.wren_BC       = r.wr_en[0];
        wr_bus.write_addr    = r.wr_addr;
        wr_bus.write_data_BO = r.bo;
        wr_bus.write_data_BD = r.bd;
        wr_bus.write_data_BC = r.bc;
        exp_q.push_back(r);
        @(posedge clock);
        #1;
        tb_thread = (tb_thread == TH - 1) ? 0 : tb_thread + 1;
        prev2 = prev1;
        prev1 = r;
        if (exp_q.size() == PIPE_DEPTH) begin
            e = exp_q.pop_front();
            check_out(e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int g = 0; g < 2 * TH && tb_thread != v.thread; g++) issue(idle_rec());
        issue(v);
    endtask

    task automatic wr_entry(input int th, input int e, input logic [PCW-1:0] bo,
                            input logic [PCW-1:0] bd, input logic [CW-1:0] bc);
        vec_t r = idle_rec();
        r.wr_en = 3'b111; r.wr_addr = (THW + EW)'(th * 4 + e);
        r.bo = bo; r.bd = bd; r.bc = bc;
        issue(r);
    endtask

    // After reset the two oldest output slots come from cleared pipeline registers.
    task automatic restart();
        tb_thread = INIT_TH;
        prev1 = idle_rec();
        prev2 = idle_rec();
        exp_q.delete();
        for (int i = 0; i < PIPE_DEPTH - 1; i++) exp_q.push_back(idle_rec());
    endtask

    initial begin
        vec_t v;
        PC = IDLE_PC; flags = '0; IO_ready_previous = 1'b1;
        wr_bus.wren_BO = 1'b0; wr_bus.wren_BD = 1'b0; wr_bus.wren_BC = 1'b0;
        wr_bus.write_addr = '0; wr_bus.write_data_BO = '0;
        wr_bus.write_data_BD = '0; wr_bus.write_data_BC = '0;

        #12;
        check_zero("reset_state");
        @(posedge clock);
        #1 reset = 1'b0;
        restart();

        for (int th = 0; th < TH; th++)
            for (int e = 0; e < 4; e++) wr_entry(th, e, '0, '0, '0);

        wr_entry(2, 1, 10'h040, 10'h080, 5'b10011);
        wr_entry(3, 3, 10'h055, 10'h099, 5'b00001);
        wr_entry(3, 2, 10'h055, 10'h09A, 5'b01001);
        wr_entry(4, 3, 10'h077, 10'h3AB, 5'b11111);
        wr_entry(5, 2, 10'h012, 10'h2C4, 5'b10110);
        wr_entry(6, 0, 10'h030, 10'h010, 5'b10000);
        wr_entry(6, 1, 10'h030, 10'h3F0, 5'b00000);
        wr_entry(6, 2, 10'h030, 10'h020, 5'b10101);

        tbl.push_back(mkv(0,  2, 10'h040, 8'h08, 1, 1, 10'h080, 1));
        tbl.push_back(mkv(1,  3, 10'h055, 8'hFF, 1, 0, 10'h000, 0));
        tbl.push_back(mkv(2,  4, 10'h077, 8'h7F, 1, 1, 10'h3AB, 3));
        tbl.push_back(mkv(3,  5, 10'h012, 8'h40, 1, 1, 10'h2C4, 2));
        tbl.push_back(mkv(4,  6, 10'h030, 8'h21, 1, 1, 10'h010, 0));
        tbl.push_back(mkv(5,  2, 10'h040, 8'hF7, 1, 0, 10'h000, 0));
        tbl.push_back(mkv(6,  3, 10'h055, 8'h00, 1, 0, 10'h000, 0));
        tbl.push_back(mkv(7,  4, 10'h077, 8'hFF, 1, 0, 10'h000, 0));
`ifdef BRANCH_CHECK_REPLAY_EN
        tbl.push_back(mkv(8,  5, 10'h012, 8'h00, 0, 1, 10'h2C4, 2));
`else
        tbl.push_back(mkv(8,  5, 10'h012, 8'h00, 0, 0, 10'h000, 0));
`endif
        tbl.push_back(mkv(9,  6, 10'h030, 8'h20, 1, 1, 10'h020, 2));
        tbl.push_back(mkv(10, 2, 10'h041, 8'hFF, 1, 0, 10'h000, 0));
        tbl.push_back(mkv(11, 5, 10'h012, 8'h00, 1, 0, 10'h000, 0));
        tbl.push_back(mkv(12, 6, 10'h030, 8'h01, 1, 1, 10'h010, 0));
`ifdef BRANCH_CHECK_REPLAY_EN
        tbl.push_back(mkv(13, 5, 10'h012, 8'h40, 0, 0, 10'h000, 0));
`else
        tbl.push_back(mkv(13, 5, 10'h012, 8'h40, 0, 1, 10'h2C4, 2));
`endif
        tbl.push_back(mkv(14, 6, 10'h030, 8'h00, 1, 0, 10'h000, 0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Negated condition, then a destination rewrite landing on the same edge as the read.
        wr_entry(2, 1, 10'h040, 10'h080, 5'b11011);
        run_vec(mkv(20, 2, 10'h040, 8'h08, 1, 0, 10'h000, 0));
        v = mkv(21, 2, 10'h040, 8'h00, 1, 1, 10'h080, 1);
        v.wr_en = 3'b010; v.wr_addr = 5'b01001; v.bd = 10'h011;
        run_vec(v);
        run_vec(mkv(22, 2, 10'h040, 8'h00, 1, 1, 10'h011, 1));

        // Mid-stream reset while a jump is on the outputs.
        wr_entry(0, 0, 10'h020, 10'h040, 5'b11000);
        run_vec(mkv(30, 4, 10'h077, 8'h7F, 1, 1, 10'h3AB, 3));
        issue(idle_rec());
        issue(idle_rec());
        #2 reset = 1'b1;
        #1 check_zero("reset_async");
        @(posedge clock);
        #1 reset = 1'b0;
        restart();
        issue(mkv(31, INIT_TH, 10'h020, 8'h00, 1, 1, 10'h040, 0));
        issue(idle_rec());
        issue(idle_rec());
        issue(idle_rec());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_check_array.md
BRANCH_CHECK_ARRAY -- requirements
Module: branch_check_array

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, meaning PC, origin and destination width.
REQ-002 SHALL have parameter THREAD_COUNT, default 8, meaning number of round-robin threads.
REQ-003 SHALL have parameter THREAD_ADDR_WIDTH, default 3, meaning clog2(THREAD_COUNT).
REQ-004 SHALL have parameter INITIAL_THREAD, default 0, meaning thread counter reset value.
REQ-005 SHALL have parameter BRANCH_COUNT, default 4, meaning branch entries per thread.
REQ-006 SHALL have parameter ENTRY_ADDR_WIDTH, default 2, meaning clog2(BRANCH_COUNT).
REQ-007 SHALL have parameter FLAGS_WIDTH, default 8, meaning flag vector width.
REQ-008 SHALL have parameter FLAGS_ADDR_WIDTH, default 3, meaning clog2(FLAGS_WIDTH).
REQ-009 SHALL have ports clock in 1 (sole clock) and reset in 1 (asynchronous, active-high).
REQ-010 SHALL have PC in PC_WIDTH, the current thread's PC.
REQ-011 SHALL have flags in FLAGS_WIDTH, the previous instruction's result flags.
REQ-012 SHALL have IO_ready_previous in 1, low when the instruction is a re-issue after an I/O stall.
REQ-013 SHALL have write ports: wren_BO, wren_BD, wren_BC in 1 each; write_addr in THREAD_ADDR_WIDTH+ENTRY_ADDR_WIDTH ({thread, entry}); write_data_BO and write_data_BD in PC_WIDTH; write_data_BC in FLAGS_ADDR_WIDTH+2 ({enable, negate, flag_sel}).
REQ-014 SHALL have outputs branch_destination out PC_WIDTH, jump out 1, jump_entry out ENTRY_ADDR_WIDTH.

Function
REQ-015 SHALL hold a thread counter that advances by one each cycle and wraps from THREAD_COUNT-1 to 0.
REQ-016 SHALL store origin, destination and condition per {thread, entry}; write is synchronous and read-during-write returns old data.
REQ-017 Cycle N: SHALL sample PC and read all BRANCH_COUNT entries of the current thread.
REQ-018 Cycle N+1: SHALL compute hit[i] = (origin[i]==PC) & enable[i].
REQ-019 Cycle N+1: SHALL compute cond[i] = flags[flag_sel[i]] ^ negate[i], with flags sampled at N+1.
REQ-020 Cycle N+2: SHALL select the lowest index i with hit[i]&cond[i]; jump_raw = 1 if such an i exists.
REQ-021 Outputs SHALL be registered and valid at N+3; when jump=0, branch_destination and jump_entry SHALL be 0 so that external OR-reduction across instances is legal.
REQ-022 Multiple hits SHALL be resolved by lowest entry index; a hit with a false condition SHALL NOT block a higher-index entry.
REQ-023 Total latency from PC to jump SHALL be exactly 3 cycles and SHALL be fully pipelined, one thread per cycle.

Reset
REQ-024 On reset assertion SHALL clear jump, branch_destination, jump_entry, pipeline registers and replay state to 0, and set the thread counter to INITIAL_THREAD, all asynchronously.
REQ-025 Branch memories SHALL NOT be reset; mid-operation reset SHALL discard in-flight decisions, with first valid output 3 cycles after deassertion.

Configuration
REQ-026 Macro BRANCH_CHECK_REPLAY_EN, when defined: a per-thread register SHALL store {jump, entry, destination} at output; if IO_ready_previous is low at N+2, that thread's stored decision SHALL be output in place of the fresh decision and the register left unchanged.
REQ-027 Without BRANCH_CHECK_REPLAY_EN: IO_ready_previous SHALL be ignored, no replay storage SHALL exist, and the fresh decision SHALL always be used.

Structure
REQ-028 A shared package SHALL hold the condition-word field offsets (ENABLE, NEGATE, FLAG_SEL) and the pipeline-depth constant 3.
REQ-029 Sub-module branch_entry_match SHALL perform the origin compare and condition evaluation for one entry and SHALL be instantiated BRANCH_COUNT times.

Verification
REQ-030 Thread 2 entry 1: origin=0x40, dest=0x80, cond={1,0,sel=3}; PC=0x40 with flags[3]=1 -> jump=1, dest=0x80, entry=1 three cycles later.
REQ-031 Same setup with flags[3]=0 -> jump=0, dest=0. With negate=1 -> jump=1, dest=0x80.
REQ-032 Entries 0 and 2 both hit with true conditions, dest 0x10 and 0x20 -> dest=0x10, entry=0; entry 0 condition false -> dest=0x20, entry=2.
REQ-033 With replay enabled: jump taken for thread 5, then re-issue with IO_ready_previous=0 and flags forcing false -> original jump=1 and destination repeated.
REQ-034 Reset asserted mid-stream while jump=1 -> outputs 0 immediately; thread counter equals INITIAL_THREAD after deassertion; first decision appears 3 cycles later.
REQ-035 Entry with enable=0 and matching origin -> jump=0 for all flag values.
